// File: rtl/dfc_rr_grant.sv
// Round-robin grant: picks the first candidate after the previous winner, wrapping modulo n_req.
// Purely combinational so several arbiters can share it.
module dfc_rr_grant #(
    parameter int unsigned n_req = 4,
    parameter int unsigned ptr_w = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic [n_req-1:0] cand_i,
    input  logic [ptr_w-1:0] last_i,
    output logic [n_req-1:0] grant_o,
    output logic [ptr_w-1:0] sel_o
);

    localparam logic [ptr_w:0] n_wide = (ptr_w + 1)'(n_req);

    logic [ptr_w:0] idx;
    logic           found;

    // NOTE: every variable driven here gets a default before the loop, otherwise the
    // paths that never find a candidate would infer latches.
    always_comb begin
        grant_o = '0;
        sel_o   = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= n_req; k++) begin
            idx = {1'b0, last_i} + (ptr_w + 1)'(k);
            if (idx >= n_wide) idx = idx - n_wide;
            if (!found && cand_i[idx[ptr_w-1:0]]) begin
                found                     = 1'b1;
                grant_o[idx[ptr_w-1:0]]   = 1'b1;
                sel_o                     = idx[ptr_w-1:0];
            end
        end
    end

endmodule

// File: rtl/dfc_arbiter.sv
// Round-robin packet arbiter driving a registered delayed-flow-control link.
// Issue decisions use a registered copy of the receiver's credit hint; grants lock for a whole packet.
module dfc_arbiter #(
    parameter int unsigned inputs = 4,
    parameter int unsigned width  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    input  logic [inputs-1:0]       c_eop,
    output logic                    p_srdy,
    output logic [width-1:0]        p_data,
    output logic                    p_eop,
    output logic [inputs-1:0]       p_grant,
    input  logic                    p_drdy
);

    localparam int unsigned      ptr_w    = (inputs > 1) ? $clog2(inputs) : 1;
    localparam logic [ptr_w-1:0] last_rst = (ptr_w)'(inputs - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ptr_w-1:0]  last_q, last_d;
    logic [ptr_w-1:0]  owner_q, owner_d;
    logic              l_drdy_q;

    logic [inputs-1:0] owner_oh, cand, grant;
    logic [ptr_w-1:0]  sel;
    logic              issue;
    logic [width-1:0]  mux_data;
    logic              mux_eop;

    logic              p_srdy_q, p_eop_q;
    logic [inputs-1:0] p_grant_q;
    logic [width-1:0]  p_data_q;

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        cand              = (state_q == LOCKED) ? (c_srdy & owner_oh) : c_srdy;
    end

    dfc_rr_grant #(
        .n_req (inputs),
        .ptr_w (ptr_w)
    ) u_rr_grant (
        .cand_i  (cand),
        .last_i  (last_q),
        .grant_o (grant),
        .sel_o   (sel)
    );

    assign issue  = l_drdy_q & (|cand);
    assign c_drdy = issue ? grant : '0;

    always_comb begin
        mux_data = '0;
        mux_eop  = 1'b0;
        for (int i = 0; i < int'(inputs); i++) begin
            if (grant[i]) begin
                mux_data = c_data[i*width +: width];
                mux_eop  = c_eop[i];
            end
        end
    end

    // Pointer only advances when a packet ends, so a locked owner is never preempted.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    if (mux_eop) begin
                        last_d = sel;
                    end else begin
                        state_d = LOCKED;
                        owner_d = sel;
                    end
                end
            end
            LOCKED: begin
                if (issue && mux_eop) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= last_rst;
            owner_q   <= '0;
            l_drdy_q  <= 1'b0;
            p_srdy_q  <= 1'b0;
            p_eop_q   <= 1'b0;
            p_grant_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            l_drdy_q  <= p_drdy;
            p_srdy_q  <= issue;
            p_eop_q   <= issue & mux_eop;
            p_grant_q <= issue ? grant : '0;
        end
    end

    // NOTE: the data register is deliberately left out of reset; it is only meaningful
    // while p_srdy is high, so a reset would add fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (issue) p_data_q <= mux_data;
    end

    assign p_srdy  = p_srdy_q;
    assign p_data  = p_data_q;
    assign p_eop   = p_eop_q;
    assign p_grant = p_grant_q;

endmodule

// File: tb/tb_dfc_arbiter.sv
// Self-checking bench for dfc_arbiter: packet generators per requester, a cycle-level
// reference model of the arbitration rules, and a credit-driven sink for the link.
module tb_dfc_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   c_srdy, c_drdy, c_eop;
    logic [N*W-1:0] c_data;
    logic           p_srdy, p_eop, p_drdy;
    logic [W-1:0]   p_data;
    logic [N-1:0]   p_grant;

    dfc_arbiter #(.inputs(N), .width(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy),
        .c_drdy  (c_drdy),
        .c_data  (c_data),
        .c_eop   (c_eop),
        .p_srdy  (p_srdy),
        .p_data  (p_data),
        .p_eop   (p_eop),
        .p_grant (p_grant),
        .p_drdy  (p_drdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester packet generators: data = {requester id, running beat count}.
    int         gen_rem[N];
    int         fixed_len[N];
    logic [5:0] gen_cnt[N];
    logic [5:0] rec_cnt[N];

    // Reference model: rr pointer and packet owner as plain integers (-1 = no owner).
    bit         m_valid = 1'b0;
    int         m_last, m_owner;
    bit         m_ldrdy;
    logic       exp_srdy, exp_eop;
    logic [W-1:0] exp_data;
    logic [N-1:0] exp_grant;

    int obs_q[$];

    function automatic int model_pick();
        if (!m_ldrdy) return -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (c_srdy[j] && (m_owner < 0 || m_owner == j)) return j;
        end
        return -1;
    endfunction

    // One clock cycle with the inputs already driven; returns at the following negedge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_cdrdy;
        #1;
        g = model_pick();
        exp_cdrdy = '0;
        if (g >= 0) exp_cdrdy[g] = 1'b1;
        if (m_valid) begin
            n_checks++;
            if (c_drdy !== exp_cdrdy) begin
                n_errors++;
                $display("FAIL c_drdy @%0t: got %b expected %b", $time, c_drdy, exp_cdrdy);
            end
        end
        if (reset) begin
            m_valid   = 1'b1;
            m_last    = N - 1;
            m_owner   = -1;
            m_ldrdy   = 1'b0;
            exp_srdy  = 1'b0;
            exp_eop   = 1'b0;
            exp_grant = '0;
            for (int i = 0; i < N; i++) gen_rem[i] = 0;
        end else begin
            if (g >= 0) begin
                exp_srdy  = 1'b1;
                exp_data  = c_data[g*W +: W];
                exp_eop   = c_eop[g];
                exp_grant = '0;
                exp_grant[g] = 1'b1;
                if (m_owner < 0) begin
                    if (c_eop[g]) m_last = g;
                    else          m_owner = g;
                end else if (c_eop[g]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
                gen_cnt[g] = gen_cnt[g] + 6'd1;
                gen_rem[g] = gen_rem[g] - 1;
            end else begin
                exp_srdy  = 1'b0;
                exp_eop   = 1'b0;
                exp_grant = '0;
            end
            m_ldrdy = p_drdy;
        end
        @(negedge clk);
        if (m_valid) begin
            n_checks++;
            if (p_srdy !== exp_srdy || p_eop !== exp_eop || p_grant !== exp_grant) begin
                n_errors++;
                $display("FAIL link ctrl @%0t: got srdy=%b eop=%b grant=%b expected srdy=%b eop=%b grant=%b",
                         $time, p_srdy, p_eop, p_grant, exp_srdy, exp_eop, exp_grant);
            end
            if (exp_srdy) begin
                n_checks++;
                if (p_data !== exp_data) begin
                    n_errors++;
                    $display("FAIL p_data @%0t: got %h expected %h", $time, p_data, exp_data);
                end
            end
        end
        if (p_srdy === 1'b1) begin
            int src;
            src = -1;
            for (int i = N - 1; i >= 0; i--) if (p_grant[i]) src = i;
            obs_q.push_back(src);
        end
    endtask

    task automatic drive(input logic [N-1:0] srdy, input bit drdy, input bit rst);
        for (int i = 0; i < N; i++) begin
            if (gen_rem[i] <= 0)
                gen_rem[i] = (fixed_len[i] > 0) ? fixed_len[i] : int'($urandom_range(1, 4));
            c_data[i*W +: W] = {2'(i), gen_cnt[i]};
            c_eop[i]         = (gen_rem[i] == 1);
        end
        c_srdy = srdy;
        p_drdy = drdy;
        reset  = rst;
        cycle();
    endtask

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        fixed_len[0] = l0;
        fixed_len[1] = l1;
        fixed_len[2] = l2;
        fixed_len[3] = l3;
    endtask

    task automatic test_reset();
        set_lens(1, 1, 1, 1);
        drive('0, 1'b0, 1'b1);
        drive('1, 1'b1, 1'b1);
        n_checks++;
        if (p_srdy !== 1'b0 || p_grant !== '0 || p_eop !== 1'b0 || c_drdy !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got srdy=%b grant=%b eop=%b c_drdy=%b expected all zero",
                     p_srdy, p_grant, p_eop, c_drdy);
        end
    endtask

    task automatic test_round_robin();
        set_lens(1, 1, 1, 1);
        drive('1, 1'b1, 1'b0);
        n_checks++;
        if (p_srdy !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_first_cycle: got p_srdy=%b expected 0", p_srdy);
        end
        obs_q.delete();
        for (int c = 0; c < 9; c++) drive('1, 1'b1, 1'b0);
        n_checks++;
        if (obs_q.size() != 9) begin
            n_errors++;
            $display("FAIL rr_beats: got %0d beats expected 9", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < 9; k++) begin
            n_checks++;
            if (obs_q[k] != k % 4) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, obs_q[k], k % 4);
            end
        end
    endtask

    task automatic test_packet_lock();
        int exp_seq[5] = '{1, 1, 1, 2, 0};
        set_lens(1, 3, 1, 1);
        drive('0, 1'b1, 1'b1);
        drive('0, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        obs_q.delete();
        for (int c = 0; c < 5; c++) drive(4'b0111, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] != exp_seq[k]) begin
                n_errors++;
                $display("FAIL lock_order[%0d]: got %0d expected %0d", k,
                         (k < obs_q.size()) ? obs_q[k] : -1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_owner_stall();
        int exp_seq[4] = '{1, 1, 1, 2};
        set_lens(1, 3, 1, 1);
        obs_q.delete();
        drive(4'b0111, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            drive(4'b0101, 1'b1, 1'b0);
            n_checks++;
            if (p_srdy !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_idle[%0d]: got p_srdy=%b expected 0", c, p_srdy);
            end
        end
        for (int c = 0; c < 3; c++) drive(4'b0111, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] != exp_seq[k]) begin
                n_errors++;
                $display("FAIL stall_order[%0d]: got %0d expected %0d", k,
                         (k < obs_q.size()) ? obs_q[k] : -1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_drdy_gap();
        set_lens(0, 0, 0, 0);
        for (int c = 0; c < 4; c++) drive('1, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive('1, 1'b0, 1'b0);
            n_checks++;
            if (p_srdy !== (c == 0)) begin
                n_errors++;
                $display("FAIL gap_low[%0d]: got p_srdy=%b expected %b", c, p_srdy, (c == 0));
            end
        end
        for (int c = 0; c < 6; c++) begin
            drive('1, 1'b1, 1'b0);
            n_checks++;
            if (p_srdy !== (c != 0)) begin
                n_errors++;
                $display("FAIL gap_high[%0d]: got p_srdy=%b expected %b", c, p_srdy, (c != 0));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        set_lens(1, 3, 1, 1);
        drive('0, 1'b1, 1'b1);
        drive('0, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0111, 1'b1, 1'b1);
        n_checks++;
        if (p_srdy !== 1'b0 || p_grant !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_pkt: got srdy=%b grant=%b expected 0 and 0000", p_srdy, p_grant);
        end
        obs_q.delete();
        drive(4'b0111, 1'b1, 1'b0);
        drive(4'b0111, 1'b1, 1'b0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] != 0) begin
            n_errors++;
            $display("FAIL reset_first_winner: got %0d beats first=%0d expected 1 beat from 0",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int sink_cnt;
        bit sink_drdy;
        set_lens(0, 0, 0, 0);
        for (int i = 0; i < N; i++) rec_cnt[i] = gen_cnt[i];
        sink_cnt  = 0;
        sink_drdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom_range(0, (1 << N) - 1)), sink_drdy, 1'b0);
            if (p_srdy === 1'b1) begin
                int src;
                src = -1;
                for (int i = N - 1; i >= 0; i--) if (p_grant[i]) src = i;
                sink_cnt++;
                n_checks++;
                if (src < 0 || p_data !== {2'(src), rec_cnt[src]}) begin
                    n_errors++;
                    $display("FAIL seq @%0t: got grant=%b data=%h", $time, p_grant, p_data);
                end else begin
                    rec_cnt[src] = rec_cnt[src] + 6'd1;
                end
            end
            n_checks++;
            if (sink_cnt > 8) begin
                n_errors++;
                $display("FAIL sink_overflow @%0t: got occupancy %0d expected <= 8", $time, sink_cnt);
            end
            if (sink_cnt > 0 && $urandom_range(0, 1) == 1) sink_cnt--;
            sink_drdy = (sink_cnt <= 3);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            gen_rem[i]   = 0;
            gen_cnt[i]   = '0;
            fixed_len[i] = 1;
        end
        c_srdy = '0;
        c_eop  = '0;
        c_data = '0;
        p_drdy = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_owner_stall();
        test_drdy_gap();
        test_reset_mid_packet();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
